// File: rtl/demoman_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demoman_pkg
//  Brief    : Shared game-state codes, winner codes and small helpers.
//  Revision : 1.0  initial release
// ============================================================================
package demoman_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      COUNTDOWN  = 3'd1,
      FIGHT      = 3'd2,
      KO_HOLD    = 3'd3,
      MATCH_OVER = 3'd4
   } game_state_t;

   localparam logic [1:0] W_NONE = 2'b00;
   localparam logic [1:0] W_P1   = 2'b01;
   localparam logic [1:0] W_P2   = 2'b10;
   localparam logic [1:0] W_DRAW = 2'b11;

   // Larger value wins; a tie (including both at zero) is a draw.
   function automatic logic [1:0] pick_winner(input logic [2:0] a, input logic [2:0] b);
      if (a > b)
         return W_P1;
      else if (b > a)
         return W_P2;
      else
         return W_DRAW;
   endfunction

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/match_controller_sec_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sec_timer
//  Brief    : Frame divider producing a seconds tick, plus a loadable 7-bit
//             seconds down-counter with a zero flag.
//  Revision : 1.0  initial release
// ============================================================================
module sec_timer #(
   parameter int FRAMES_PER_SEC = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_frame_tick,
   input  logic       i_load,
   input  logic [6:0] i_load_val,
   output logic       o_sec_tick,
   output logic       o_expire,
   output logic       o_zero
);

   localparam int c_CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(FRAMES_PER_SEC - 1);

   logic [c_CW-1:0] r_frame_cnt;
   logic [6:0]      r_secs;

   assign o_sec_tick = i_frame_tick && (r_frame_cnt == c_LAST);
   // Expire flags the tick that takes the counter from 1 to 0.
   assign o_expire   = o_sec_tick && (r_secs == 7'd1);
   assign o_zero     = (r_secs == 7'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt <= '0;
         r_secs      <= 7'd0;
      end else if (i_load) begin
         r_frame_cnt <= '0;
         r_secs      <= i_load_val;
      end else if (i_frame_tick) begin
         if (o_sec_tick) begin
            r_frame_cnt <= '0;
            if (r_secs != 7'd0)
               r_secs <= r_secs - 7'd1;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
//  Module   : match_controller
//  Brief    : Round/match sequencer: countdown, fight timer, KO/time-out,
//             win tally, match end and player gating.
//  Revision : 1.0  initial release
// ============================================================================
module match_controller
   import demoman_pkg::*;
#(
   parameter int FRAMES_PER_SEC = 60,
   parameter int COUNTDOWN_SEC  = 3,
   parameter int ROUND_SEC      = 99,
   parameter int KO_HOLD_SEC    = 2,
   parameter int WINS_TO_MATCH  = 2,
   parameter int MAX_ROUNDS     = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [2:0] p1_health,
   input  logic [2:0] p2_health,
   output logic [2:0] game_state,
   output logic       players_active,
   output logic       round_rst,
   output logic [1:0] countdown,
   output logic [6:0] timer_sec,
   output logic [2:0] round_num,
   output logic [1:0] p1_wins,
   output logic [1:0] p2_wins,
   output logic [1:0] round_winner,
   output logic [1:0] match_winner
);

   localparam logic [1:0] c_CD_SEC    = 2'(COUNTDOWN_SEC);
   localparam logic [6:0] c_CD_LOAD   = 7'(COUNTDOWN_SEC);
   localparam logic [6:0] c_ROUND_SEC = 7'(ROUND_SEC);
   localparam logic [6:0] c_KO_LOAD   = 7'(KO_HOLD_SEC);
   localparam logic [1:0] c_WINS      = 2'(WINS_TO_MATCH);
   localparam logic [2:0] c_MAX_RND   = 3'(MAX_ROUNDS);

   game_state_t r_state;
   logic        r_start_d;

   logic        w_start_edge;
   logic        w_ko;
   logic        w_sec_tick;
   logic        w_expire;
   logic        w_sec_zero;
   logic        w_load;
   logic [6:0]  w_load_val;
   logic        w_match_done;
   logic [1:0]  w_round_result;
   logic [1:0]  w_match_result;

   assign w_start_edge   = start & ~r_start_d;
   assign w_ko           = (p1_health == 3'd0) || (p2_health == 3'd0);
   assign w_round_result = pick_winner(p1_health, p2_health);
   assign w_match_result = pick_winner({1'b0, p1_wins}, {1'b0, p2_wins});
   assign w_match_done   = (p1_wins >= c_WINS) || (p2_wins >= c_WINS) ||
                           (round_num >= c_MAX_RND);
   assign game_state     = r_state;

   // The seconds counter is reloaded on every state transition with the
   // duration that the destination state runs for.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = c_CD_LOAD;
      case (r_state)
         IDLE, MATCH_OVER: w_load = w_start_edge;
         COUNTDOWN: begin
            w_load     = w_expire;
            w_load_val = c_ROUND_SEC;
         end
         FIGHT: begin
            w_load     = w_ko | w_expire;
            w_load_val = c_KO_LOAD;
         end
         KO_HOLD:  w_load = w_expire;
         default:  w_load = 1'b0;
      endcase
   end

   sec_timer #(
      .FRAMES_PER_SEC (FRAMES_PER_SEC)
   ) u_sec_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_tick (frame_tick),
      .i_load       (w_load),
      .i_load_val   (w_load_val),
      .o_sec_tick   (w_sec_tick),
      .o_expire     (w_expire),
      .o_zero       (w_sec_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_start_d      <= 1'b0;
         players_active <= 1'b0;
         round_rst      <= 1'b0;
         countdown      <= 2'd0;
         timer_sec      <= c_ROUND_SEC;
         round_num      <= 3'd0;
         p1_wins        <= 2'd0;
         p2_wins        <= 2'd0;
         round_winner   <= W_NONE;
         match_winner   <= W_NONE;
      end else begin
         r_start_d <= start;
         round_rst <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_edge) begin
                  r_state      <= COUNTDOWN;
                  round_rst    <= 1'b1;
                  countdown    <= c_CD_SEC;
                  timer_sec    <= c_ROUND_SEC;
                  round_num    <= 3'd1;
                  p1_wins      <= 2'd0;
                  p2_wins      <= 2'd0;
                  round_winner <= W_NONE;
                  match_winner <= W_NONE;
               end
            end
            COUNTDOWN: begin
               if (w_expire) begin
                  r_state        <= FIGHT;
                  countdown      <= 2'd0;
                  players_active <= 1'b1;
               end else if (w_sec_tick && countdown != 2'd0) begin
                  countdown <= countdown - 2'd1;
               end
            end
            FIGHT: begin
               if (w_sec_tick && !w_sec_zero && timer_sec != 7'd0)
                  timer_sec <= timer_sec - 7'd1;
               // KO and time-out share one judgement: KO'd player has 0 health.
               if (w_ko || w_expire) begin
                  r_state        <= KO_HOLD;
                  players_active <= 1'b0;
                  round_winner   <= w_round_result;
                  case (w_round_result)
                     W_P1:    p1_wins <= sat_inc(p1_wins);
                     W_P2:    p2_wins <= sat_inc(p2_wins);
                     default: ;
                  endcase
               end
            end
            KO_HOLD: begin
               if (w_expire) begin
                  if (w_match_done) begin
                     r_state      <= MATCH_OVER;
                     match_winner <= w_match_result;
                  end else begin
                     r_state   <= COUNTDOWN;
                     round_rst <= 1'b1;
                     countdown <= c_CD_SEC;
                     timer_sec <= c_ROUND_SEC;
                     round_num <= round_num + 3'd1;
                  end
               end
            end
            MATCH_OVER: begin
               if (w_start_edge) begin
                  r_state      <= IDLE;
                  countdown    <= 2'd0;
                  timer_sec    <= c_ROUND_SEC;
                  round_num    <= 3'd0;
                  p1_wins      <= 2'd0;
                  p2_wins      <= 2'd0;
                  round_winner <= W_NONE;
                  match_winner <= W_NONE;
               end
            end
            default: begin
               r_state        <= IDLE;
               players_active <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
